// File: rtl/uart_frame_rx_if.sv
// uart_frame_rx_if: byte-stream input and frame/payload outputs of uart_frame_rx.
// The err_count/err_count_clr pair exists only when UART_FRAME_ERR_CNT_EN is defined.
interface uart_frame_rx_if;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] dout;
    logic       dout_valid;
    logic       frame_start;
    logic [7:0] frame_len;
    logic       frame_done;
    logic       frame_err;
    logic [1:0] err_code;
`ifdef UART_FRAME_ERR_CNT_EN
    logic [7:0] err_count;
    logic       err_count_clr;
`endif

    // Upstream side: the UART receiver plus the frame consumer.
    modport master (
        output rx_data, rx_done,
`ifdef UART_FRAME_ERR_CNT_EN
        output err_count_clr,
        input  err_count,
`endif
        input  dout, dout_valid, frame_start, frame_len,
        input  frame_done, frame_err, err_code
    );

    // Deframer side.
    modport slave (
        input  rx_data, rx_done,
`ifdef UART_FRAME_ERR_CNT_EN
        input  err_count_clr,
        output err_count,
`endif
        output dout, dout_valid, frame_start, frame_len,
        output frame_done, frame_err, err_code
    );
endinterface

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: delineates SOF/LEN/payload/CHK frames from a UART byte stream,
// streams payload bytes out and validates length, XOR checksum and byte spacing.
// Optional saturating error counter enabled by defining UART_FRAME_ERR_CNT_EN.
module uart_frame_rx #(
    parameter logic [7:0]  SOF     = 8'hA5,
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned TIMEOUT = 50000,
    parameter int unsigned TO_BIT  = 16
) (
    input logic           clk,
    input logic           reset,
    uart_frame_rx_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CHK
    } state_t;

    localparam logic [TO_BIT-1:0] TO_LAST = TO_BIT'(TIMEOUT - 1);
    localparam logic [7:0]        LEN_MAX = 8'(MAX_LEN);

    state_t            r_state;
    logic [7:0]        r_remain;
    logic [7:0]        r_chk;
    logic [TO_BIT-1:0] r_to_cnt;
    logic [7:0]        r_dout;
    logic              r_dout_valid;
    logic              r_frame_start;
    logic [7:0]        r_frame_len;
    logic              r_frame_done;
    logic              r_frame_err;
    logic [1:0]        r_err_code;

    logic w_len_ok;
    assign w_len_ok = (bus.rx_data != 8'h00) && (bus.rx_data <= LEN_MAX);

    // Frame state machine with registered outputs; pulses default low every cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_remain      <= '0;
            r_chk         <= '0;
            r_to_cnt      <= '0;
            r_dout        <= '0;
            r_dout_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_len   <= '0;
            r_frame_done  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_err_code    <= '0;
        end else begin
            r_dout_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_err   <= 1'b0;
            if (r_state == ST_IDLE) begin
                r_to_cnt <= '0;
                if (bus.rx_done && (bus.rx_data == SOF)) begin
                    r_state <= ST_LEN;
                end
            end else if (bus.rx_done) begin
                // A byte arriving on the timeout cycle still wins.
                r_to_cnt <= '0;
                case (r_state)
                    ST_LEN: begin
                        if (w_len_ok) begin
                            r_frame_len   <= bus.rx_data;
                            r_remain      <= bus.rx_data;
                            r_chk         <= bus.rx_data;
                            r_frame_start <= 1'b1;
                            r_state       <= ST_DATA;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_err_code  <= 2'b01;
                            r_state     <= ST_IDLE;
                        end
                    end
                    ST_DATA: begin
                        r_dout       <= bus.rx_data;
                        r_dout_valid <= 1'b1;
                        r_chk        <= r_chk ^ bus.rx_data;
                        r_remain     <= r_remain - 8'd1;
                        if (r_remain == 8'd1) begin
                            r_state <= ST_CHK;
                        end
                    end
                    ST_CHK: begin
                        if (bus.rx_data == r_chk) begin
                            r_frame_done <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_err_code  <= 2'b10;
                        end
                        r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end else if (r_to_cnt == TO_LAST) begin
                r_to_cnt    <= '0;
                r_frame_err <= 1'b1;
                r_err_code  <= 2'b11;
                r_state     <= ST_IDLE;
            end else begin
                r_to_cnt <= r_to_cnt + TO_BIT'(1);
            end
        end
    end

    assign bus.dout        = r_dout;
    assign bus.dout_valid  = r_dout_valid;
    assign bus.frame_start = r_frame_start;
    assign bus.frame_len   = r_frame_len;
    assign bus.frame_done  = r_frame_done;
    assign bus.frame_err   = r_frame_err;
    assign bus.err_code    = r_err_code;

`ifdef UART_FRAME_ERR_CNT_EN
    logic [7:0] r_err_count;

    // Count visible frame_err pulses, saturating; a clear in the same cycle takes priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_count <= '0;
        end else if (bus.err_count_clr) begin
            r_err_count <= '0;
        end else if (r_frame_err && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign bus.err_count = r_err_count;
`endif

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: directed checks of uart_frame_rx (TIMEOUT overridden to 100).
module tb_uart_frame_rx;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   n_dv, n_fs, n_fd, n_fe, n_both;

    uart_frame_rx_if bus ();

    uart_frame_rx #(
        .SOF     (8'hA5),
        .MAX_LEN (16),
        .TIMEOUT (100),
        .TO_BIT  (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tally output pulses just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (bus.dout_valid)  n_dv++;
        if (bus.frame_start) n_fs++;
        if (bus.frame_done)  n_fd++;
        if (bus.frame_err)   n_fe++;
        if (bus.frame_done && bus.frame_err) n_both++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one byte for a single cycle; returns one cycle later when the response is visible.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        @(negedge clk);
        bus.rx_done = 1'b0;
        bus.rx_data = 8'h00;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dout"},  bus.dout, 0);
        check({tag, "_dv"},    bus.dout_valid, 0);
        check({tag, "_fs"},    bus.frame_start, 0);
        check({tag, "_flen"},  bus.frame_len, 0);
        check({tag, "_fd"},    bus.frame_done, 0);
        check({tag, "_fe"},    bus.frame_err, 0);
        check({tag, "_ecode"}, bus.err_code, 0);
`ifdef UART_FRAME_ERR_CNT_EN
        check({tag, "_ecnt"},  bus.err_count, 0);
`endif
    endtask

    initial begin
        int dv0, fe0, fd0;
        checks = 0; errors = 0;
        n_dv = 0; n_fs = 0; n_fd = 0; n_fe = 0; n_both = 0;
        reset = 1'b0;
        bus.rx_data = 8'h00;
        bus.rx_done = 1'b0;
`ifdef UART_FRAME_ERR_CNT_EN
        bus.err_count_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;

        // Valid frame A5 03 11 22 33 03
        send(8'hA5);
        check("v_sof_fs", bus.frame_start, 0);
        send(8'h03);
        check("v_len_fs", bus.frame_start, 1);
        check("v_len_flen", bus.frame_len, 8'h03);
        send(8'h11);
        check("v_d0_dv", bus.dout_valid, 1);
        check("v_d0", bus.dout, 8'h11);
        send(8'h22);
        check("v_d1", bus.dout, 8'h22);
        send(8'h33);
        check("v_d2_dv", bus.dout_valid, 1);
        check("v_d2", bus.dout, 8'h33);
        send(8'h03);
        check("v_chk_fd", bus.frame_done, 1);
        check("v_chk_fe", bus.frame_err, 0);
        check("v_cnt_dv", n_dv, 3);
        check("v_cnt_fe", n_fe, 0);

        // Bad checksum A5 02 10 20 00
        send(8'hA5);
        send(8'h02);
        send(8'h10);
        check("bc_d0", bus.dout, 8'h10);
        send(8'h20);
        check("bc_d1", bus.dout, 8'h20);
        send(8'h00);
        check("bc_fe", bus.frame_err, 1);
        check("bc_fd", bus.frame_done, 0);
        check("bc_code", bus.err_code, 2'b10);

        // Bad length: zero and above MAX_LEN
        dv0 = n_dv;
        send(8'hA5);
        send(8'h00);
        check("bl0_fe", bus.frame_err, 1);
        check("bl0_code", bus.err_code, 2'b01);
        check("bl0_flen", bus.frame_len, 8'h02);
        send(8'hA5);
        send(8'h11);
        check("bl17_fe", bus.frame_err, 1);
        check("bl17_code", bus.err_code, 2'b01);
        check("bl17_flen", bus.frame_len, 8'h02);
        send(8'h10);
        check("bl_idle_dv", bus.dout_valid, 0);
        check("bl_cnt_dv", n_dv, dv0);

        // Timeout after A5 02 55 with 100 idle cycles
        send(8'hA5);
        send(8'h02);
        send(8'h55);
        check("to_d0", bus.dout, 8'h55);
        repeat (99) @(negedge clk);
        check("to_c99_fe", bus.frame_err, 0);
        @(negedge clk);
        check("to_c100_fe", bus.frame_err, 1);
        check("to_code", bus.err_code, 2'b11);

        // Byte landing on the last timeout cycle is accepted
        fe0 = n_fe;
        send(8'hA5);
        send(8'h01);
        repeat (98) @(negedge clk);
        send(8'h7E);
        check("tb_dv", bus.dout_valid, 1);
        check("tb_dout", bus.dout, 8'h7E);
        check("tb_fe", bus.frame_err, 0);
        send(8'h7F);
        check("tb_fd", bus.frame_done, 1);
        check("tb_cnt_fe", n_fe, fe0);

        // Garbage in IDLE, then reset mid-frame
        dv0 = n_dv; fe0 = n_fe; fd0 = n_fd;
        send(8'h00);
        send(8'hFF);
        send(8'h5A);
        check("g_cnt_dv", n_dv, dv0);
        check("g_cnt_fe", n_fe, fe0);
        check("g_cnt_fd", n_fd, fd0);
        check("g_cnt_fs", n_fs, 4);
        send(8'hA5);
        send(8'h04);
        send(8'h01);
        check("g_d0", bus.dout, 8'h01);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        reset = 1'b1;
        send(8'hA5);
        send(8'h01);
        check("pr_flen", bus.frame_len, 8'h01);
        send(8'h42);
        check("pr_dout", bus.dout, 8'h42);
        send(8'h43);
        check("pr_fd", bus.frame_done, 1);
        check("pr_cnt_fe", n_fe, fe0);

`ifdef UART_FRAME_ERR_CNT_EN
        // Saturating error counter and clear priority
        for (int i = 0; i < 300; i++) begin
            send(8'hA5);
            send(8'h00);
        end
        @(negedge clk);
        check("ec_sat", bus.err_count, 8'hFF);
        send(8'hA5);
        send(8'h00);
        check("ec_fe_vis", bus.frame_err, 1);
        bus.err_count_clr = 1'b1;
        @(negedge clk);
        bus.err_count_clr = 1'b0;
        check("ec_clr", bus.err_count, 8'h00);
`endif

        check("never_both", n_both, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
- Sits directly downstream of the UART receiver; consumes its byte stream (rx_data qualified by the one-cycle rx_done pulse).
- Delineates framed packets, streams payload bytes out, and validates each frame by length and XOR checksum.
- Frame format: SOF byte, LEN byte, LEN payload bytes, CHK byte, where CHK = LEN ^ payload[0] ^ … ^ payload[LEN-1].
- Feeds the command/decode logic, which needs no UART knowledge.

Parameters:
- SOF, 8'hA5: start-of-frame marker byte.
- MAX_LEN, 16: largest legal LEN value (1..255).
- TIMEOUT, 50000: clk cycles allowed between consecutive bytes inside a frame.
- TO_BIT, 16: width of the inter-byte timeout counter; must satisfy 2^TO_BIT > TIMEOUT.

Ports:
- clk  in  1  system clock, the same clock as the UART receiver.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte; valid only when rx_done=1.
- rx_done  in  1  one-cycle pulse marking a new byte.
- dout  out  8  payload byte.
- dout_valid  out  1  one-cycle pulse; dout holds a payload byte.
- frame_start  out  1  one-cycle pulse when a legal LEN is accepted.
- frame_len  out  8  LEN of the current or last frame; held until the next legal LEN.
- frame_done  out  1  one-cycle pulse; frame checksum correct.
- frame_err  out  1  one-cycle pulse; frame aborted.
- err_code  out  2  cause of the last frame_err: 01 bad LEN, 10 checksum, 11 timeout; held until the next error.

Behaviour:
- Clock and reset: one clock domain; all state updates on the rising edge of clk.
- Reset (reset=0, asynchronous): state=IDLE. Every output is 0, including dout, frame_len and err_code. The checksum accumulator and the timeout counter are 0.
- Registering: all outputs are registered. Every response to a byte appears exactly 1 cycle after its rx_done pulse.
- The block has no back-pressure. The consumer must accept each dout_valid pulse.
- Byte spacing: consecutive rx_done pulses are ≥1 cycle apart, and all byte arrival orders are supported.
- IDLE:
  - rx_done with rx_data==SOF → go to LEN.
  - Any other byte is silently discarded; no output pulses.
- LEN:
  - rx_done with 1 ≤ rx_data ≤ MAX_LEN → capture frame_len, set remaining count = rx_data, set chk = rx_data, pulse frame_start, go to DATA.
  - rx_done with rx_data==0 or rx_data > MAX_LEN → pulse frame_err with err_code=01, go to IDLE.
- DATA:
  - Each rx_done → dout=rx_data, pulse dout_valid, chk ^= rx_data, decrement the count.
  - When the last payload byte is accepted (count reaches 0), go to CHK.
- CHK:
  - rx_done with rx_data==chk → pulse frame_done.
  - Otherwise → pulse frame_err with err_code=10.
  - Either case → go to IDLE.
- Timeout:
  - In LEN, DATA or CHK, the counter increments every cycle and clears on every rx_done.
  - When the counter reaches TIMEOUT-1 without an rx_done → pulse frame_err with err_code=11, go to IDLE.
  - In IDLE the counter is held at 0.
- Boundary rules:
  - rx_done in the same cycle the counter reaches TIMEOUT-1: the byte wins, it is processed normally, and the counter clears.
  - SOF value appearing as LEN, payload or CHK is treated as data; there is no resynchronisation mid-frame.
  - Payload bytes already emitted before an error are not retracted. Consumers must discard a partial frame on frame_err.
  - frame_done and frame_err are never asserted together.
  - Reset mid-frame aborts the frame with no error pulse.
- Arithmetic:
  - The remaining count is 8 bits and never underflows, because the exit to CHK happens at the last payload byte.
  - The checksum is a plain 8-bit XOR.

Optional Feature:
- Macro: UART_FRAME_ERR_CNT_EN.
- When defined:
  - Adds output err_count [7:0].
  - err_count increments on every frame_err pulse and saturates at 8'hFF.
  - err_count resets to 0 on reset=0.
  - Adds input err_count_clr [1], which zeroes err_count synchronously.
  - If err_count_clr and frame_err occur in the same cycle, the clear wins.
- When undefined: neither port exists and there is no counter logic; all other behaviour is identical.

Test Plan:
- Valid frame: bytes A5,03,11,22,33,03 (CHK = 03^11^22^33 = 03) → frame_start, frame_len=3, dout_valid×3 with 11,22,33, then frame_done. No frame_err.
- Bad checksum: A5,02,10,20,00 → dout 10,20, then frame_err with err_code=10. No frame_done.
- Bad length: A5,00, then A5,11 with MAX_LEN=16 → frame_err with err_code=01 each time. No dout_valid, and frame_len keeps its previous value.
- Timeout (TIMEOUT=100): A5,02,55, then 100 idle cycles → frame_err with err_code=11 on the 100th cycle. A following A5,01,7E,7F is accepted with frame_done.
- Garbage and reset: 00,FF,5A in IDLE → no outputs. Then A5,04,01, and reset=0 asserted mid-frame → all outputs 0 immediately and state IDLE. A fresh A5,01,42,43 → frame_done.
- With UART_FRAME_ERR_CNT_EN defined: drive 300 bad-length frames → err_count=FF. Then assert err_count_clr together with a frame_err → err_count=00.
